vout_frame_read_ctrl: RTL
=========================

VOUT_FRAME_READ_CTRL -- requirements
Module: vout_frame_read_ctrl

Interface
REQ-001 The module SHALL have parameter MEM_DATA_BITS, default 64, giving the memory data word width.
REQ-002 The module SHALL have parameter BURST_LEN, default 32, giving the maximum burst length in memory words.
REQ-003 The module SHALL have parameter FIFO_DEPTH, default 1024, giving the output FIFO depth in memory words.
REQ-004 mem_clk  in  1  the single clock; all logic runs on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 vout_vs  in  1  output-side vertical sync, asynchronous to mem_clk.
REQ-007 vout_width  in  12  line length in memory words.
REQ-008 vout_height  in  12  lines per frame.
REQ-009 rd_burst_req  out  1  burst read request.
REQ-010 rd_burst_len  out  10  burst length in words.
REQ-011 rd_burst_addr  out  24  burst start word address.
REQ-012 rd_burst_data_valid  in  1  read beat valid.
REQ-013 rd_burst_data  in  MEM_DATA_BITS  read beat data.
REQ-014 burst_finish  in  1  one-cycle pulse ending the current burst.
REQ-015 fifo_wrreq  out  1  output FIFO write strobe.
REQ-016 fifo_wrdata  out  MEM_DATA_BITS  output FIFO write data.
REQ-017 fifo_wrusedw  in  12  output FIFO fill level in words.
REQ-018 fifo_aclr  out  1  one-cycle output FIFO clear pulse.
REQ-019 frame_done  out  1  one-cycle pulse when the last line of a frame has been read.

Function
REQ-020 vout_vs SHALL pass through a two-flop synchronizer; frame_flag SHALL be a one-cycle pulse on its synchronized rising edge.
REQ-021 fifo_aclr SHALL equal frame_flag, registered one cycle later.
REQ-022 States SHALL be IDLE, LINE_START, WAIT_SPACE, BURSTING, BURST_END, LINE_END, FRAME_DONE and FLUSH.
REQ-023 IDLE: go to LINE_START when frame_flag is seen and vout_height != 0; otherwise stay in IDLE.
REQ-024 LINE_START: load rd_burst_addr = {2'b0, line[10:0], 11'b0} and remain = vout_width; go to LINE_END if vout_width == 0, else go to WAIT_SPACE.
REQ-025 WAIT_SPACE: go to BURSTING when fifo_wrusedw <= FIFO_DEPTH - 2*BURST_LEN.
  - On entry to BURSTING, set rd_burst_len = min(remain, BURST_LEN) and rd_burst_req = 1.
REQ-026 rd_burst_req SHALL clear on the first rd_burst_data_valid or on burst_finish, whichever comes first.
REQ-027 BURSTING: go to BURST_END on burst_finish.
REQ-028 BURST_END: rd_burst_addr += rd_burst_len and remain -= rd_burst_len, both in one cycle; go to LINE_END if the new remain == 0, else go to WAIT_SPACE.
REQ-029 LINE_END: line += 1; go to FRAME_DONE if the new line == vout_height, else go to LINE_START.
REQ-030 FRAME_DONE: pulse frame_done once, then wait for frame_flag.
REQ-031 fifo_wrreq and fifo_wrdata SHALL be rd_burst_data_valid and rd_burst_data registered, giving 1-cycle latency.
  - Beats beyond rd_burst_len within one burst SHALL be dropped.
REQ-032 frame_flag in IDLE, WAIT_SPACE, BURST_END, LINE_START, LINE_END or FRAME_DONE SHALL set line = 0 and restart at LINE_START next cycle.
REQ-033 frame_flag while rd_burst_req is high or while BURSTING SHALL enter FLUSH.
  - FLUSH suppresses fifo_wrreq until burst_finish, then sets line = 0 and goes to LINE_START.
REQ-034 frame_flag coincident with burst_finish SHALL take the restart path of REQ-032; no write of that beat SHALL reach the FIFO.
REQ-035 The line counter is 12 bits; only line[10:0] forms the address, so lines beyond 2047 wrap the address.
REQ-036 vout_width and vout_height SHALL be sampled only in LINE_START and LINE_END respectively.

Reset
REQ-037 While rst_n is low, the module SHALL hold state = IDLE, line = 0, remain = 0, and the synchronizer flops at 0.
REQ-038 While rst_n is low, all outputs SHALL be 0: rd_burst_req, rd_burst_len, rd_burst_addr, fifo_wrreq, fifo_wrdata, fifo_aclr, frame_done.
REQ-039 After reset the block SHALL issue no request until the first frame_flag.

Structure
REQ-040 The burst state encodings and BURST_LEN SHALL be shared package constants, common with the write-side frame buffer controller.
REQ-041 The vs synchronizer and edge detector SHALL be the sub-module vs_edge_sync, reusable by other frame-sync logic.

Verification
REQ-042 vout_width=64, vout_height=2, then vs edge -> four bursts of len 32 at addresses 0x000000, 0x000020, 0x000800, 0x000820; 128 fifo_wrreq; one frame_done.
REQ-043 vout_width=40 -> per line, bursts of len 32 then len 8; the second burst address is line base + 32.
REQ-044 fifo_wrusedw held at 961 -> no rd_burst_req; dropping it to 960 -> rd_burst_req within 2 cycles.
REQ-045 vs edge during a burst that has 10 of 32 beats delivered -> the remaining 22 beats are not written, fifo_aclr pulses, and the next request is at address 0x000000 after burst_finish.
REQ-046 rst_n low mid-burst -> all outputs are 0 immediately; after release, no request until a vs edge.
REQ-047 vout_width=0, vout_height=3 -> no bursts; frame_done pulses after 3 LINE_END passes.

Source files
------------

// File: rtl/vout_frame_read_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vout_frame_read_ctrl_pkg: burst FSM encoding and burst-size helpers  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package vout_frame_read_ctrl_pkg;

  localparam int DEF_BURST_LEN = 32;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LINE_START = 3'd1,
    ST_WAIT_SPACE = 3'd2,
    ST_BURSTING   = 3'd3,
    ST_BURST_END  = 3'd4,
    ST_LINE_END   = 3'd5,
    ST_FRAME_DONE = 3'd6,
    ST_FLUSH      = 3'd7
  } burst_state_e;

  // Words for the next burst: whatever is left of the line, capped at max_len.
  function automatic logic [9:0] burst_words(input logic [11:0] remain,
                                             input int unsigned max_len);
    logic [11:0] cap;
    cap = 12'(max_len);
    return (remain < cap) ? remain[9:0] : cap[9:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/vs_edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vs_edge_sync: two-flop synchronizer with rising-edge pulse output    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vs_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/vout_frame_read_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vout_frame_read_ctrl: reads a video frame line by line in bursts     |
// | from frame memory into the output FIFO.           Rev 1.0            |
// +----------------------------------------------------------------------+
module vout_frame_read_ctrl
  import vout_frame_read_ctrl_pkg::*;
#(
  parameter int MEM_DATA_BITS = 64,
  parameter int BURST_LEN     = DEF_BURST_LEN,
  parameter int FIFO_DEPTH    = 1024
) (
  input  logic                     mem_clk,
  input  logic                     rst_n,
  input  logic                     vout_vs,
  input  logic [11:0]              vout_width,
  input  logic [11:0]              vout_height,
  output logic                     rd_burst_req,
  output logic [9:0]               rd_burst_len,
  output logic [23:0]              rd_burst_addr,
  input  logic                     rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
  input  logic                     burst_finish,
  output logic                     fifo_wrreq,
  output logic [MEM_DATA_BITS-1:0] fifo_wrdata,
  input  logic [11:0]              fifo_wrusedw,
  output logic                     fifo_aclr,
  output logic                     frame_done
);

  localparam logic [11:0] SPACE_THRESH = 12'(FIFO_DEPTH - 2 * BURST_LEN);

  logic frame_flag;

  burst_state_e state_q, state_d;
  logic [11:0]  line_q, line_d;
  logic [11:0]  remain_q, remain_d;
  logic [23:0]  addr_q, addr_d;
  logic [9:0]   len_q, len_d;
  logic [9:0]   beat_cnt_q, beat_cnt_d;
  logic         req_q, req_d;
  logic         done_q, done_d;
  logic         wr_q, wr_d;
  logic         aclr_q;
  logic [MEM_DATA_BITS-1:0] wrdata_q;

  vs_edge_sync u_vs_sync (
    .clk_i  (mem_clk),
    .rst_ni (rst_n),
    .async_i(vout_vs),
    .rise_o (frame_flag)
  );

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      line_q     <= '0;
      remain_q   <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      wr_q       <= 1'b0;
      wrdata_q   <= '0;
      aclr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      remain_q   <= remain_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      req_q      <= req_d;
      done_q     <= done_d;
      wr_q       <= wr_d;
      wrdata_q   <= rd_burst_data;
      aclr_q     <= frame_flag;
    end
  end

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    remain_d   = remain_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    req_d      = req_q;
    done_d     = 1'b0;

    if (req_q && (rd_burst_data_valid || burst_finish)) req_d = 1'b0;
    if (rd_burst_data_valid && (state_q == ST_BURSTING || state_q == ST_FLUSH))
      beat_cnt_d = beat_cnt_q + 10'd1;

    // A new vs edge discards the beat arriving with it; surplus beats are dropped.
    wr_d = rd_burst_data_valid && (state_q == ST_BURSTING) &&
           (beat_cnt_q < len_q) && !frame_flag;

    case (state_q)
      ST_IDLE: begin
        if (frame_flag && (vout_height != 12'd0)) begin
          line_d  = '0;
          state_d = ST_LINE_START;
        end
      end
      ST_LINE_START: begin
        if (frame_flag) begin
          line_d = '0;
        end else begin
          addr_d   = {2'b00, line_q[10:0], 11'b0};
          remain_d = vout_width;
          state_d  = (vout_width == 12'd0) ? ST_LINE_END : ST_WAIT_SPACE;
        end
      end
      ST_WAIT_SPACE: begin
        if (frame_flag) begin
          line_d  = '0;
          state_d = ST_LINE_START;
        end else if (fifo_wrusedw <= SPACE_THRESH) begin
          len_d      = burst_words(remain_q, BURST_LEN);
          req_d      = 1'b1;
          beat_cnt_d = '0;
          state_d    = ST_BURSTING;
        end
      end
      ST_BURSTING: begin
        if (frame_flag && burst_finish) begin
          line_d  = '0;
          state_d = ST_LINE_START;
        end else if (frame_flag) begin
          state_d = ST_FLUSH;
        end else if (burst_finish) begin
          state_d = ST_BURST_END;
        end
      end
      ST_BURST_END: begin
        if (frame_flag) begin
          line_d  = '0;
          state_d = ST_LINE_START;
        end else begin
          addr_d   = addr_q + {14'b0, len_q};
          remain_d = remain_q - {2'b00, len_q};
          state_d  = (remain_q == {2'b00, len_q}) ? ST_LINE_END : ST_WAIT_SPACE;
        end
      end
      ST_LINE_END: begin
        if (frame_flag) begin
          line_d  = '0;
          state_d = ST_LINE_START;
        end else begin
          line_d = line_q + 12'd1;
          if ((line_q + 12'd1) == vout_height) begin
            done_d  = 1'b1;
            state_d = ST_FRAME_DONE;
          end else begin
            state_d = ST_LINE_START;
          end
        end
      end
      ST_FRAME_DONE: begin
        if (frame_flag) begin
          line_d  = '0;
          state_d = ST_LINE_START;
        end
      end
      ST_FLUSH: begin
        if (burst_finish) begin
          line_d  = '0;
          state_d = ST_LINE_START;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_burst_req  = req_q;
  assign rd_burst_len  = len_q;
  assign rd_burst_addr = addr_q;
  assign fifo_wrreq    = wr_q;
  assign fifo_wrdata   = wrdata_q;
  assign fifo_aclr     = aclr_q;
  assign frame_done    = done_q;

endmodule
`default_nettype wire
